// File: rtl/ram_scan_viewer_if.sv
// Switch/display bundle for ram_scan_viewer: mode, address, data and wren in; q, cur_addr, busy and done out.
// Latency: none, wires only.
// Backpressure: none. The master owns the switch-side inputs and the slave owns the display-side outputs.
//   mode     : 00 manual, 01 scan, 10 clear request, 11 manual
//   address  : manual read/write address
//   data     : manual write data
//   wren     : write switch level; a rising edge commits one write
//   q        : registered read data
//   cur_addr : address that produced the current q
//   busy     : high while a clear is in progress
//   done     : one-cycle pulse when a clear completes
interface ram_scan_viewer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [1:0]        mode;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] cur_addr;
    logic              busy;
    logic              done;

    modport master (
        output mode, address, data, wren,
        input  q, cur_addr, busy, done
    );

    modport slave (
        input  mode, address, data, wren,
        output q, cur_addr, busy, done
    );
endinterface

// File: rtl/ram_scan_viewer.sv
// Single-port RAM viewer with manual write/read, divided-rate address scan and a hardware zero-fill.
// Latency: q and cur_addr are registered together, one cycle after the read address. Clear takes DEPTH cycles.
// Backpressure: none. Inputs are sampled every cycle, mode is ignored during a clear, and a write edge outside IDLE is dropped.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high reset (RAM contents are kept)
//   bus      : slave side of ram_scan_viewer_if (mode/address/data/wren in; q/cur_addr/busy/done out)
module ram_scan_viewer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 25000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    ram_scan_viewer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_scan_ptr;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DIV_W-1:0]  r_div;
    logic              r_wren_d;
    logic [DATA_W-1:0] r_q;
    logic [ADDR_W-1:0] r_cur_addr;
    logic              r_done;

    logic              w_wr_pulse;
    logic              w_scan_tc;
    logic              w_clr_last;
    logic              w_clr_entry;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_busy;

    assign w_wr_pulse  = bus.wren & ~r_wren_d;
    assign w_scan_tc   = (r_div == DIV_LAST);
    assign w_clr_last  = (r_clr_ptr == ADDR_LAST);
    assign w_clr_entry = (r_state != ST_CLEAR) && (w_next_state == ST_CLEAR);

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; mode 11 behaves as manual
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.mode == 2'b10)      w_next_state = ST_CLEAR;
                else if (bus.mode == 2'b01) w_next_state = ST_SCAN;
            end
            ST_SCAN: begin
                if (bus.mode == 2'b10)      w_next_state = ST_CLEAR;
                else if (bus.mode != 2'b01) w_next_state = ST_IDLE;
            end
            ST_CLEAR: begin
                // mode is deliberately not looked at until the fill finishes
                if (w_clr_last)             w_next_state = ST_IDLE;
            end
            default:                        w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: read-address mux, RAM write port, busy
    always_comb begin
        w_rd_addr   = bus.address;
        w_mem_we    = 1'b0;
        w_mem_waddr = bus.address;
        w_mem_wdata = bus.data;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mem_we = w_wr_pulse;
            end
            ST_SCAN: begin
                w_rd_addr = r_scan_ptr;
            end
            ST_CLEAR: begin
                w_rd_addr   = r_clr_ptr;
                w_mem_we    = 1'b1;
                w_mem_waddr = r_clr_ptr;
                w_mem_wdata = '0;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // RAM array has no reset, but a reset edge must not commit the in-flight
    // clear write, so words not yet zeroed stay untouched on abort.
    always_ff @(posedge CLOCK_50) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Scan divider and pointer, clear pointer, write-edge history, done pulse
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_scan_ptr <= '0;
            r_clr_ptr  <= '0;
            r_div      <= '0;
            r_wren_d   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wren_d <= bus.wren;
            r_done   <= (r_state == ST_CLEAR) && w_clr_last;

            // Divider idles at zero outside SCAN, so every entry starts a fresh
            // step; the pointer itself is only cleared by reset.
            if (r_state == ST_SCAN) begin
                if (w_scan_tc) begin
                    r_div      <= '0;
                    r_scan_ptr <= r_scan_ptr + ADDR_W'(1);
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_div <= '0;
            end

            if (w_clr_entry) begin
                r_clr_ptr <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            end
        end
    end

    // Registered read port: read-first on a same-address write because the
    // array update and this read share the same edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_q        <= '0;
            r_cur_addr <= '0;
        end else begin
            r_q        <= r_mem[w_rd_addr];
            r_cur_addr <= w_rd_addr;
        end
    end

    assign bus.q        = r_q;
    assign bus.cur_addr = r_cur_addr;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_ram_scan_viewer.sv
// Directed self-checking bench for ram_scan_viewer with ADDR_W=5, DATA_W=8 and SCAN_DIV=4.
// Latency: outputs are sampled 1 time unit after each rising edge, and inputs are driven at that same point.
// Backpressure: not applicable. Every step runs a fixed number of cycles, and a watchdog bounds the whole run.
module tb_ram_scan_viewer;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int SCAN_DIV = 4;
    localparam int DEPTH    = 32;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ram_scan_viewer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_scan_viewer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.address = a;
        bus.data    = d;
        bus.wren    = 1'b1;
        tick();
        bus.wren    = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.mode    = 2'b00;
        bus.address = '0;
        bus.data    = '0;
        bus.wren    = 1'b0;
        tick();
        tick();
        check("reset_q",        32'(bus.q),        32'h0);
        check("reset_cur_addr", 32'(bus.cur_addr), 32'h0);
        check("reset_busy",     32'(bus.busy),     32'h0);
        check("reset_done",     32'(bus.done),     32'h0);
        reset = 1'b0;
        tick();

        // Manual write then read back
        write_word(5'd3, 8'hA5);
        check("manual_q",        32'(bus.q),        32'hA5);
        check("manual_cur_addr", 32'(bus.cur_addr), 32'h3);

        // Held wren: the data change while the switch stays high must not be written
        bus.data = 8'hA5;
        bus.wren = 1'b1;
        tick();
        bus.data = 8'h3C;
        repeat (9) tick();
        check("held_wren_q", 32'(bus.q), 32'hA5);
        bus.wren = 1'b0;
        tick();
        bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        tick();
        check("rewrite_q", 32'(bus.q), 32'h3C);

        // Read-during-write on the same address is read-first
        write_word(5'd7, 8'h11);
        bus.address = 5'd7;
        bus.data    = 8'h22;
        bus.wren    = 1'b1;
        tick();
        check("rdw_old_q", 32'(bus.q), 32'h11);
        bus.wren = 1'b0;
        tick();
        check("rdw_new_q", 32'(bus.q), 32'h22);

        // Preload mem[i] = i, then scan; wren toggles with address 5 / data FF throughout
        for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), DATA_W'(i));
        bus.address = 5'd5;
        bus.data    = 8'hFF;
        bus.mode    = 2'b01;
        tick();
        for (int k = 1; k <= 136; k++) begin
            bus.wren = k[0];
            tick();
            check("scan_cur_addr", 32'(bus.cur_addr), 32'(((k - 1) / 4) % DEPTH));
            check("scan_q",        32'(bus.q),        32'(((k - 1) / 4) % DEPTH));
        end
        // 34 steps taken, so the frozen pointer is 2
        bus.mode = 2'b00;
        bus.wren = 1'b0;
        tick();
        tick();
        tick();
        check("scan_no_write_q", 32'(bus.q), 32'h5);
        bus.mode = 2'b01;
        tick();
        tick();
        check("scan_resume_cur_addr", 32'(bus.cur_addr), 32'h2);
        check("scan_resume_q",        32'(bus.q),        32'h2);
        bus.mode = 2'b11;
        tick();
        tick();
        bus.address = 5'd9;
        tick();
        check("mode11_manual_cur_addr", 32'(bus.cur_addr), 32'h9);
        bus.mode = 2'b00;

        // Clear: one cycle of mode=10; mode changes during the fill are ignored
        bus.mode = 2'b10;
        tick();
        for (int k = 0; k < 32; k++) begin
            check("clear_busy", 32'(bus.busy), 32'h1);
            check("clear_done", 32'(bus.done), 32'h0);
            bus.mode = (k == 31) ? 2'b00 : 2'(k % 4);
            tick();
        end
        check("clear_end_busy", 32'(bus.busy), 32'h0);
        check("clear_end_done", 32'(bus.done), 32'h1);
        tick();
        check("clear_after_done", 32'(bus.done), 32'h0);
        check("clear_after_busy", 32'(bus.busy), 32'h0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.address = ADDR_W'(a);
            tick();
            check("clear_read_q",    32'(bus.q),        32'h0);
            check("clear_read_addr", 32'(bus.cur_addr), 32'(a));
        end

        // Reset partway through a clear
        for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), DATA_W'(i + 8'h40));
        bus.mode = 2'b10;
        tick();
        bus.mode = 2'b00;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("abort_busy",     32'(bus.busy),     32'h0);
        check("abort_q",        32'(bus.q),        32'h0);
        check("abort_cur_addr", 32'(bus.cur_addr), 32'h0);
        check("abort_done",     32'(bus.done),     32'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", 32'(bus.done), 32'h0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.address = ADDR_W'(a);
            tick();
            check("abort_read_q", 32'(bus.q), (a < 10) ? 32'h0 : 32'(a + 8'h40));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_scan_viewer.md
Name: ram_scan_viewer

Overview:
- Parametrised on-chip RAM with a display-ready read port, sized for DE2 switch/HEX-style front ends.
- Three operating modes:
  - manual: switch-driven address, data and write.
  - scan: self-stepping address walk at a divided rate.
  - clear: hardware zero-fill of the whole array.
- Writes are edge-triggered, so a held write switch commits exactly once.
- Sits between the board-level switch inputs and the hex decoders. The registered read data and address are presented together so the displays always agree.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width.
- SCAN_DIV, 25000000, clock cycles per scan step. Legal range is 1 or more.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  00 manual, 01 scan, 10 clear request, 11 treated as manual.
- address  in  ADDR_W  manual read/write address.
- data  in  DATA_W  manual write data.
- wren  in  1  write request (level from switch; rising edge commits).
- q  out  DATA_W  registered read data.
- cur_addr  out  ADDR_W  address that produced the current q.
- busy  out  1  high while a clear is in progress.
- done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (sampled on CLOCK_50 edge):
  - q=0, cur_addr=0, busy=0, done=0.
  - state=IDLE, scan pointer=0, divider=0, wren_d=0, clear pointer=0.
  - RAM contents are not reset.
- States: IDLE (manual), SCAN, CLEAR.
- Transitions:
  - IDLE to SCAN when mode=01.
  - IDLE or SCAN to CLEAR when mode=10.
  - SCAN to IDLE when mode=00 or 11.
  - CLEAR to IDLE unconditionally after the last word is written.
  - The mode input is ignored while in CLEAR.
- Read path:
  - rd_addr = scan pointer in SCAN, clear pointer in CLEAR, otherwise address.
  - Every cycle: q <= mem[rd_addr] and cur_addr <= rd_addr. Latency is 1 cycle.
- Write edge detection:
  - wren_d <= wren every cycle, in every state.
  - wr_pulse = wren & ~wren_d.
- Manual write: in IDLE, when wr_pulse=1, mem[address] <= data.
  - Holding wren high produces no further writes.
  - wr_pulse in SCAN or CLEAR is discarded; it is not deferred.
- Read-during-write to the same address is read-first: q shows the old word and the new word appears on the next cycle.
- SCAN mode:
  - Divider counts 0 to SCAN_DIV-1. On the terminal count it returns to 0 and the scan pointer increments.
  - The scan pointer wraps from DEPTH-1 to 0.
  - On entry to SCAN, divider=0 and the scan pointer keeps its prior value. The pointer is cleared only by reset.
  - Leaving SCAN freezes the scan pointer.
- CLEAR mode:
  - On entry: clear pointer=0 and busy=1.
  - Each cycle: mem[clear pointer] <= 0 and clear pointer increments. Takes exactly DEPTH cycles.
  - On the cycle after the write to DEPTH-1: busy=0, done=1 for one cycle, state=IDLE.
  - If mode is still 10 in IDLE, a new clear starts on the next cycle (re-trigger while held).
- Reset mid-clear: abort immediately. Words already zeroed stay zeroed; the rest are untouched. busy=0 and no done pulse.
- Width rules: all pointers are ADDR_W bits with natural wrap. The divider is clog2(SCAN_DIV) bits, minimum 1.

Test Plan:
- Manual write/read (ADDR_W=5, DATA_W=8): address=3, data=A5, toggle wren 0-1 -> mem[3]=A5. With address=3: q=A5 and cur_addr=3 one cycle later.
- Held wren: wren held high for 10 cycles while data changes A5 to 3C -> only A5 is written. Lower then raise wren with data=3C -> mem[3]=3C.
- Scan with SCAN_DIV=4, after preloading mem[i]=i:
  - mode=01 -> cur_addr steps 0,1,2,... every 4 cycles, with q equal to cur_addr.
  - After address 31 the next value is 0 (wrap).
  - wren toggled during scan -> memory unchanged.
- Clear: preload nonzero, then mode=10 for one cycle -> busy high for 32 cycles and done pulses once. Then in manual: every address reads 00. Mode changes during the clear have no effect.
- Reset mid-clear: assert reset at clear cycle 10 -> next cycle busy=0, q=0, cur_addr=0, no done pulse. Addresses 0-9 read 00 and addresses 10-31 keep their preload.
- Read-during-write: mem[7]=11, address=7, wren rising edge with data=22 -> q=11 on the first cycle, then 22 on the next.
